// File: rtl/led_serial_driver_pkg.sv
// Shared types and defaults for the LED serial-bus driver.
package led_serial_driver_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned CLK_DIV_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/led_serial_driver_if.sv
// Request handshake plus the four-wire LED shift-register bus.
interface led_serial_driver_if
    import led_serial_driver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic                  led_clk;
    logic                  led_dat;
    logic                  led_pen;
    logic                  led_clrn;

    modport master (
        output start, data_in,
        input  ready, led_clk, led_dat, led_pen, led_clrn
    );

    modport slave (
        input  start, data_in,
        output ready, led_clk, led_dat, led_pen, led_clrn
    );

endinterface

// File: rtl/led_serial_driver_shiftreg.sv
// Enabled shift register: parallel load or right shift with a serial fill bit.
module led_serial_driver_shiftreg #(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en_i,
    input  logic                 shiftn_loadp_i,
    input  logic                 shift_in_i,
    input  logic [BIT_WIDTH-1:0] load_i,
    output logic [BIT_WIDTH-1:0] q_o
);

    logic [BIT_WIDTH-1:0] q_q;
    logic [BIT_WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            if (shiftn_loadp_i) begin
                q_d = load_i;
            end else begin
                q_d = {shift_in_i, q_q[BIT_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/led_serial_driver.sv
// Shifts one parallel word LSB-first onto the LED chain with a divided
// serial clock, then pulses the latch enable.
module led_serial_driver
    import led_serial_driver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF
) (
    input logic                clk,
    input logic                rstn,
    led_serial_driver_if.slave bus
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);
    localparam int unsigned BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    state_e                state_q;
    state_e                state_d;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  ready_q;
    logic                  ready_d;
    logic                  clk_q;
    logic                  clk_d;
    logic                  dat_q;
    logic                  dat_d;
    logic                  pen_q;
    logic                  pen_d;
    logic                  clrn_q;
    logic                  sr_en;
    logic                  sr_load;
    logic                  accept;
    logic                  div_end;
    logic                  bit_end;
    logic                  unused_shift;

    assign accept       = (state_q == ST_IDLE) && bus.start;
    assign div_end      = (div_q == DIV_LAST);
    assign bit_end      = (bit_q == BIT_LAST);
    assign unused_shift = ^shift_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (clk_q && div_end && bit_end) state_d = ST_LATCH;
            ST_LATCH: if (div_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bit edges happen at the end of the high phase; led_dat moves only then,
    // except on the final bit where it holds through LATCH and IDLE.
    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        clk_d   = 1'b0;
        dat_d   = dat_q;
        sr_en   = 1'b0;
        sr_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) data_d = bus.data_in;
            end
            ST_LOAD: begin
                sr_en   = 1'b1;
                sr_load = 1'b1;
                div_d   = '0;
                bit_d   = '0;
                dat_d   = data_q[0];
            end
            ST_SHIFT: begin
                clk_d = clk_q;
                if (div_end) begin
                    div_d = '0;
                    clk_d = ~clk_q;
                    if (clk_q) begin
                        sr_en = 1'b1;
                        if (bit_end) begin
                            bit_d = '0;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                            dat_d = shift_q[1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                div_d = div_end ? '0 : div_q + DIV_W'(1);
            end
            default: ;
        endcase
        ready_d = (state_d == ST_IDLE);
        pen_d   = (state_d == ST_LATCH);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            clk_q   <= 1'b0;
            dat_q   <= 1'b0;
            pen_q   <= 1'b0;
            clrn_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            pen_q   <= pen_d;
            clrn_q  <= 1'b1;
        end
    end

    led_serial_driver_shiftreg #(
        .BIT_WIDTH (DATA_WIDTH)
    ) u_shiftreg (
        .clk            (clk),
        .rstn           (rstn),
        .en_i           (sr_en),
        .shiftn_loadp_i (sr_load),
        .shift_in_i     (1'b0),
        .load_i         (data_q),
        .q_o            (shift_q)
    );

    assign bus.ready    = ready_q;
    assign bus.led_clk  = clk_q;
    assign bus.led_dat  = dat_q;
    assign bus.led_pen  = pen_q;
    assign bus.led_clrn = clrn_q;

endmodule

// File: tb/tb_led_serial_driver.sv
// Directed bench: a 16-bit/div-2 instance and a 2-bit/div-1 corner instance.
module tb_led_serial_driver;

    localparam int unsigned WA = 16;
    localparam int unsigned DA = 2;
    localparam int unsigned WB = 2;
    localparam int unsigned DB = 1;
    localparam int EXP_BUSY_A = 67;
    localparam int EXP_PEN_A  = 2;

    typedef struct {
        logic [15:0] data;
        logic [15:0] seq;     // expected serial bits, first-in-time at MSB
        int          inject;  // cycle at which a stray start is pulsed, -1 none
        string       name;
    } vec_a_t;

    typedef struct {
        logic [1:0] data;
        logic [5:0] clk_seq;  // per cycle after accept, first at MSB
        logic [5:0] dat_seq;
        logic [5:0] pen_seq;
        logic [5:0] rdy_seq;
    } vec_b_t;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    vec_a_t vecs_a[4];
    vec_b_t vecs_b[2];

    led_serial_driver_if #(.DATA_WIDTH(WA)) if_a ();
    led_serial_driver_if #(.DATA_WIDTH(WB)) if_b ();

    led_serial_driver #(.DATA_WIDTH(WA), .CLK_DIV(DA)) u_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_a)
    );

    led_serial_driver #(.DATA_WIDTH(WB), .CLK_DIV(DB)) u_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Observes instance A from just after its accepting edge until ready returns.
    task automatic watch_a(input logic [15:0] seq, input int inject, input string nm);
        int   cyc;
        int   rises;
        int   pens;
        logic prev_clk;
        logic held;
        cyc = 0; rises = 0; pens = 0; prev_clk = 1'b0; held = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            if (inject >= 0) begin
                if (cyc == inject) begin
                    if_a.start   = 1'b1;
                    if_a.data_in = 16'hFFFF;
                end else begin
                    if_a.start = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (if_a.led_clk && !prev_clk) begin
                if (rises < 16) chk({nm, "_bit"}, 32'(if_a.led_dat), 32'(seq[15-rises]));
                rises++;
                held = if_a.led_dat;
            end else if (if_a.led_clk) begin
                chk({nm, "_hold"}, 32'(if_a.led_dat), 32'(held));
            end
            if (if_a.led_pen) begin
                pens++;
                chk({nm, "_pen_clk"}, 32'(if_a.led_clk), 32'd0);
            end
            prev_clk = if_a.led_clk;
            if (if_a.ready) break;
        end
        chk({nm, "_busy"}, 32'(cyc), 32'(EXP_BUSY_A));
        chk({nm, "_rises"}, 32'(rises), 32'd16);
        chk({nm, "_pen_len"}, 32'(pens), 32'(EXP_PEN_A));
    endtask

    task automatic xfer_a(input logic [15:0] d, input logic [15:0] seq, input int inject,
                          input string nm);
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = d;
        @(posedge clk); #1;
        chk({nm, "_accept"}, 32'(if_a.ready), 32'd0);
        if_a.start = 1'b0;
        watch_a(seq, inject, nm);
        @(posedge clk); #1;
        chk({nm, "_idle_rdy"}, 32'(if_a.ready), 32'd1);
        chk({nm, "_idle_pen"}, 32'(if_a.led_pen), 32'd0);
    endtask

    initial begin
        int rises;
        int n;
        int pens;
        logic prev_clk;

        total = 0;
        bad   = 0;

        vecs_a[0] = '{16'hA5C3, 16'b1100001110100101, -1, "a5c3"};
        vecs_a[1] = '{16'h0001, 16'b1000000000000000, 10, "busy_start"};
        vecs_a[2] = '{16'h8000, 16'b0000000000000001, -1, "msb_only"};
        vecs_a[3] = '{16'h3C96, 16'b0110100100111100, -1, "3c96"};
        vecs_b[0] = '{2'b10, 6'b010100, 6'b001111, 6'b000010, 6'b000001};
        vecs_b[1] = '{2'b01, 6'b010100, 6'b110000, 6'b000010, 6'b000001};

        // Reset held with start asserted: reset must win.
        rstn         = 1'b0;
        if_a.start   = 1'b1;
        if_a.data_in = 16'hA5C3;
        if_b.start   = 1'b1;
        if_b.data_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ready", 32'(if_a.ready), 32'd1);
            chk("rst_clk", 32'(if_a.led_clk), 32'd0);
            chk("rst_dat", 32'(if_a.led_dat), 32'd0);
            chk("rst_pen", 32'(if_a.led_pen), 32'd0);
            chk("rst_clrn", 32'(if_a.led_clrn), 32'd0);
            chk("rst_b_ready", 32'(if_b.ready), 32'd1);
            chk("rst_b_clrn", 32'(if_b.led_clrn), 32'd0);
        end
        @(negedge clk);
        rstn       = 1'b1;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        @(posedge clk); #1;
        chk("rel_clrn", 32'(if_a.led_clrn), 32'd1);
        chk("rel_ready", 32'(if_a.ready), 32'd1);
        chk("rel_b_clrn", 32'(if_b.led_clrn), 32'd1);
        chk("rel_b_ready", 32'(if_b.ready), 32'd1);

        for (int v = 0; v < 4; v++) begin
            xfer_a(vecs_a[v].data, vecs_a[v].seq, vecs_a[v].inject, vecs_a[v].name);
        end

        // Back-to-back with start held high across both transfers.
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = 16'h00FF;
        @(posedge clk); #1;
        chk("b2b_acc1", 32'(if_a.ready), 32'd0);
        if_a.data_in = 16'hFF00;
        watch_a(16'b1111111100000000, -1, "b2b1");
        @(posedge clk); #1;
        chk("b2b_acc2", 32'(if_a.ready), 32'd0);
        if_a.start = 1'b0;
        watch_a(16'b0000000011111111, -1, "b2b2");
        @(posedge clk); #1;
        chk("b2b_idle", 32'(if_a.ready), 32'd1);

        // Reset after the fifth rising serial clock.
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = 16'hA5C3;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        rises = 0; n = 0; prev_clk = 1'b0;
        while (rises < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (if_a.led_clk && !prev_clk) rises++;
            prev_clk = if_a.led_clk;
        end
        chk("abort_reached", 32'(rises), 32'd5);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(if_a.ready), 32'd1);
        chk("abort_clk", 32'(if_a.led_clk), 32'd0);
        chk("abort_dat", 32'(if_a.led_dat), 32'd0);
        chk("abort_pen", 32'(if_a.led_pen), 32'd0);
        chk("abort_clrn", 32'(if_a.led_clrn), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        pens = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (if_a.led_pen) pens++;
        end
        chk("abort_no_pen", 32'(pens), 32'd0);
        chk("abort_still_idle", 32'(if_a.ready), 32'd1);
        xfer_a(16'h0001, 16'b1000000000000000, -1, "post_abort");

        // Corner instance: one-cycle half-periods, two-bit words.
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            if_b.start   = 1'b1;
            if_b.data_in = vecs_b[v].data;
            @(posedge clk); #1;
            chk("b_accept", 32'(if_b.ready), 32'd0);
            if_b.start = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                chk("b_clk", 32'(if_b.led_clk), 32'(vecs_b[v].clk_seq[5-i]));
                chk("b_dat", 32'(if_b.led_dat), 32'(vecs_b[v].dat_seq[5-i]));
                chk("b_pen", 32'(if_b.led_pen), 32'(vecs_b[v].pen_seq[5-i]));
                chk("b_ready", 32'(if_b.ready), 32'(vecs_b[v].rdy_seq[5-i]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_serial_driver.md
# led_serial_driver

Serialises a parallel LED pattern onto the board's four-wire shift-register LED bus: serial clock, serial data, latch enable and clear. It sits upstream of the LED shift-register chain. It accepts one DATA_WIDTH-bit word per transaction over a start/ready handshake, then shifts the word out LSB-first with a divided serial clock. A latch pulse then transfers the word to the LED outputs.

## Interface
- DATA_WIDTH, 16: bits per transfer; must be ≥ 2.
- CLK_DIV, 4: system cycles per serial-clock half-period; must be ≥ 1.
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  reset, synchronous and active-low.
- start  input  1  request; accepted on any edge where start=1 and ready=1.
- data_in  input  DATA_WIDTH  pattern; sampled only on the accepting edge.
- ready  output  1  high only in IDLE.
- led_clk  output  1  serial clock to the LED chain; registered.
- led_dat  output  1  serial data; registered.
- led_pen  output  1  latch enable; active-high pulse; registered.
- led_clrn  output  1  chain clear, active-low; registered.

## Operation
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - ready=1, led_clk=0, led_pen=0.
  - On an accepting edge: capture data_in and go to LOAD.
  - start while not IDLE is ignored; it is neither queued nor stored.
- LOAD: lasts exactly one cycle, during which the shift stage parallel-loads; then go to SHIFT with bit_cnt=0 and div_cnt=0.
- SHIFT: each bit occupies 2·CLK_DIV cycles.
  - Low phase: CLK_DIV cycles with led_clk=0 and led_dat=shift_q[0].
  - High phase: CLK_DIV cycles with led_clk=1.
  - On the last cycle of the high phase, shift the stage right (MSB fill 0) and increment bit_cnt.
  - After bit DATA_WIDTH−1 completes, go to LATCH.
- LATCH: led_pen=1 for exactly CLK_DIV cycles with led_clk=0; then return to IDLE.
- led_dat changes only on the edge that drops led_clk or while led_clk=0. It is stable for the CLK_DIV cycles on each side of every rising led_clk.
- led_dat holds its last value in LATCH and IDLE.
- led_clrn: 0 while in reset; 1 from the first edge after rstn returns high.
- Counters: div_cnt is $clog2(CLK_DIV)+1 bits wide and bit_cnt is $clog2(DATA_WIDTH)+1 bits wide. Both are unsigned and wrap to 0 at the end of each phase or transfer, never by overflow.

## Timing
- Reset (rstn=0 at an edge): state=IDLE; ready=1, led_clk=0, led_dat=0, led_pen=0, led_clrn=0, all counters 0, shift stage 0.
- Accepting edge E0: ready=0 from E0 onward.
  - Rising led_clk edges occur after E(1+CLK_DIV+2·CLK_DIV·k) for k=0..DATA_WIDTH−1.
  - led_pen=1 from after E(1+2·W·D) through E(1+2·W·D+D), where W=DATA_WIDTH and D=CLK_DIV.
  - ready=1 again after E(1+2·W·D+D).
  - Defaults: 133 cycles of busy time.
- Back-to-back: start held high in the first IDLE cycle is accepted immediately, giving one idle cycle between transfers.
- rstn=0 mid-transfer:
  - Abort on that edge; all outputs take reset values.
  - No led_pen pulse is generated.
  - The partial word is discarded.
- rstn=0 together with start: reset wins and nothing is accepted.

## Structure
- Shared include led_drv_defs.vh holds:
  - state encoding localparams: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, LATCH=2'd3;
  - the default DATA_WIDTH and CLK_DIV.
- The natural sub-module is the team's ShiftReg, instantiated with:
  - BIT_WIDTH=DATA_WIDTH;
  - shiftn_loadp driven high in LOAD;
  - shift clocked via a one-cycle enable, realised by holding the loaded value outside shift edges;
  - shift_in=0.
- FSM, divider and bit counter stay in led_serial_driver.

## Test plan
- Reset: hold rstn=0 for 3 cycles → ready=1, led_clk=0, led_dat=0, led_pen=0, led_clrn=0. One edge after release → led_clrn=1.
- Single word with DATA_WIDTH=16, CLK_DIV=2, data_in=16'hA5C3:
  - Exactly 16 rising led_clk edges sample led_dat = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - led_pen is high for 2 cycles after the 16th bit.
  - ready returns 67 cycles after the accepting edge.
- Start while busy: pulse start with data_in=16'hFFFF at cycle 10 of a 16'h0001 transfer → the serial stream is still 1 followed by fifteen 0s, and only one led_pen pulse occurs.
- Reset mid-transfer: assert rstn=0 after the 5th rising led_clk → next edge shows reset values, no led_pen pulse, and a new start is accepted normally afterwards.
- Back-to-back with start held high, words 16'h00FF then 16'hFF00 → two complete streams and two led_pen pulses, with one ready=1 cycle between them.
- Corner case CLK_DIV=1, DATA_WIDTH=2, data=2'b10 → led_clk toggles every cycle, bits sampled are 0 then 1, led_pen lasts 1 cycle, and busy time is 1+4+1=6 cycles.
